// File: rtl/keypad_pkg.sv
// Shared constants and the row/column to key-code map for the keypad scanner.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  localparam key_code_t NOKEY    = 4'd10;
  localparam key_code_t KEY_STAR = 4'd11;
  localparam key_code_t KEY_HASH = 4'd12;

  localparam int ROWS = 4;
  localparam int COLS = 3;

  // Rows 0-2 hold digits 1-9; the bottom row is '*', '0', '#'.
  function automatic key_code_t keymap(input logic [1:0] row, input logic [1:0] col);
    key_code_t code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key event bundle from the keypad scanner to its consumer (the clock core).
interface keypad_scanner_if;
  import keypad_pkg::*;

  key_code_t key;
  logic      key_valid;
  logic      key_held;

  modport master (output key, key_valid, key_held);
  modport slave  (input  key, key_valid, key_held);
endinterface

// File: rtl/keypad_debounce.sv
// Scan-level debouncer: accepts a code after DEBOUNCE_SCANS matching scans.
// Auto-repeat strobes are built only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 2,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      scan_end,
  input  key_code_t scan_code,
  output key_code_t key,
  output logic      key_valid,
  output logic      key_held
);

  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  key_code_t     cand_reg, cand_next;
  logic [SW-1:0] stable_reg, stable_next;
  logic          accept;

  always_comb begin
    cand_next   = cand_reg;
    stable_next = stable_reg;
    if (scan_code == cand_reg) begin
      if (stable_reg != STABLE_MAX) stable_next = stable_reg + 1'b1;
    end else begin
      cand_next   = scan_code;
      stable_next = SW'(1);
    end
  end

  assign accept = scan_end && (stable_next == STABLE_MAX) && (cand_next != key);

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);
  logic [RW-1:0] rep_cnt_reg;
`else
  logic [31:0] repeat_unused;
  assign repeat_unused = 32'(REPEAT_SCANS);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_reg    <= NOKEY;
      stable_reg  <= '0;
      key         <= NOKEY;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (scan_end) begin
        cand_reg   <= cand_next;
        stable_reg <= stable_next;
      end
      // Release updates the code silently; only real keys strobe.
      if (accept) begin
        key       <= cand_next;
        key_held  <= (cand_next != NOKEY);
        key_valid <= (cand_next != NOKEY);
      end
`ifdef KEYPAD_REPEAT_EN
      if (accept) begin
        rep_cnt_reg <= '0;
      end else if (scan_end) begin
        if ((key != NOKEY) && (scan_code == key)) begin
          if (rep_cnt_reg == REP_LAST) begin
            rep_cnt_reg <= '0;
            key_valid   <= 1'b1;
          end else begin
            rep_cnt_reg <= rep_cnt_reg + 1'b1;
          end
        end else begin
          rep_cnt_reg <= '0;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, row sync, per-scan hit accumulation.
// Optional auto-repeat in the debouncer is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 2,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ROWS-1:0]          row_n,
  output logic [COLS-1:0]          col_n,
  keypad_scanner_if.master         kif
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [1:0]    LAST_COL   = 2'(COLS - 1);

  logic [ROWS-1:0] row_meta_reg, row_sync_reg;
  logic [DW-1:0]   dwell_reg;
  logic [1:0]      col_idx_reg;
  logic [1:0]      hit_cnt_reg;
  key_code_t       hit_code_reg;
  logic            scan_end_reg;
  key_code_t       scan_code_reg;

  logic            sample;
  logic [ROWS-1:0] pressed;
  key_code_t       row_code [ROWS];
  logic [2:0]      col_hits;
  key_code_t       col_code;
  logic [2:0]      total_hits;
  logic [1:0]      merged_cnt;
  key_code_t       merged_code;

  assign col_n  = ~(3'b001 << col_idx_reg);
  assign sample = (dwell_reg == DWELL_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      assign pressed[gi]  = ~row_sync_reg[gi];
      assign row_code[gi] = keymap(2'(gi), col_idx_reg);
    end
  endgenerate

  // Hit count saturates at 2: anything above one press is a multi-key scan.
  always_comb begin
    col_hits = '0;
    col_code = NOKEY;
    for (int r = 0; r < ROWS; r++) begin
      if (pressed[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = row_code[r];
      end
    end
    total_hits  = col_hits + ((col_idx_reg == 2'd0) ? 3'd0 : {1'b0, hit_cnt_reg});
    merged_cnt  = (total_hits > 3'd1) ? 2'd2 : total_hits[1:0];
    merged_code = (col_hits != 3'd0) ? col_code : hit_code_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_reg  <= '1;
      row_sync_reg  <= '1;
      dwell_reg     <= '0;
      col_idx_reg   <= '0;
      hit_cnt_reg   <= '0;
      hit_code_reg  <= NOKEY;
      scan_end_reg  <= 1'b0;
      scan_code_reg <= NOKEY;
    end else begin
      row_meta_reg <= row_n;
      row_sync_reg <= row_meta_reg;
      scan_end_reg <= 1'b0;
      if (sample) begin
        dwell_reg    <= '0;
        col_idx_reg  <= (col_idx_reg == LAST_COL) ? 2'd0 : col_idx_reg + 2'd1;
        hit_cnt_reg  <= merged_cnt;
        hit_code_reg <= merged_code;
        if (col_idx_reg == LAST_COL) begin
          scan_end_reg  <= 1'b1;
          scan_code_reg <= (merged_cnt == 2'd1) ? merged_code : NOKEY;
        end
      end else begin
        dwell_reg <= dwell_reg + 1'b1;
      end
    end
  end

  key_code_t key;
  logic      key_valid;
  logic      key_held;

  keypad_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
    .REPEAT_SCANS   (REPEAT_SCANS)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .scan_end  (scan_end_reg),
    .scan_code (scan_code_reg),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  assign kif.key       = key;
  assign kif.key_valid = key_valid;
  assign kif.key_held  = key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a column-driven keypad model.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row_n;
  logic [2:0] col_n;
  logic [11:0] pressed = '0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int base;
  logic prev_kv = 1'b0;
  logic double_seen = 1'b0;
  logic nokey_seen = 1'b0;

  keypad_scanner_if kif ();

  keypad_scanner dut (
    .clk   (clk),
    .reset (reset),
    .row_n (row_n),
    .col_n (col_n),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  // A pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (kif.key_valid) pulses <= pulses + 1;
    if (kif.key_valid && prev_kv) double_seen <= 1'b1;
    if (kif.key_valid && kif.key == 4'd10) nokey_seen <= 1'b1;
    prev_kv <= kif.key_valid;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int  seq_idx [5] = '{10, 9, 11, 4, 7};
  int  seq_key [5] = '{0, 11, 12, 5, 8};

  initial begin
    // Reset state and column rotation
    cycles(2);
    check("rst_col_n", 32'(col_n), 32'(3'b110));
    check("rst_key", 32'(kif.key), 32'd10);
    check("rst_valid", 32'(kif.key_valid), 32'd0);
    check("rst_held", 32'(kif.key_held), 32'd0);
    reset = 1'b0;
    cycles(4);
    check("col_1", 32'(col_n), 32'(3'b101));
    cycles(4);
    check("col_2", 32'(col_n), 32'(3'b011));
    cycles(4);
    check("col_wrap", 32'(col_n), 32'(3'b110));

    // Press 5 for 4 scans then release
    base = pulses;
    pressed = 12'd1 << 4;
    cycles(24);
    check("k5_before", 32'(kif.key), 32'd10);
    cycles(1);
    check("k5_key", 32'(kif.key), 32'd5);
    check("k5_valid", 32'(kif.key_valid), 32'd1);
    check("k5_held", 32'(kif.key_held), 32'd1);
    cycles(1);
    check("k5_valid_drop", 32'(kif.key_valid), 32'd0);
    cycles(22);
    pressed = '0;
    cycles(24);
    check("rel_before", 32'(kif.key), 32'd5);
    cycles(1);
    check("rel_key", 32'(kif.key), 32'd10);
    check("rel_held", 32'(kif.key_held), 32'd0);
    cycles(11);
    check("k5_pulses", 32'(pulses - base), 32'd1);

    // One-scan bounce of key 3
    base = pulses;
    pressed = 12'd1 << 2;
    cycles(12);
    pressed = '0;
    cycles(36);
    check("bounce_key", 32'(kif.key), 32'd10);
    check("bounce_pulses", 32'(pulses - base), 32'd0);

    // Keys 1+2 together, then keep only 1
    base = pulses;
    pressed = 12'b011;
    cycles(48);
    check("multi_key", 32'(kif.key), 32'd10);
    check("multi_pulses", 32'(pulses - base), 32'd0);
    pressed = 12'b001;
    cycles(24);
    check("k1_before", 32'(kif.key), 32'd10);
    cycles(1);
    check("k1_key", 32'(kif.key), 32'd1);
    check("k1_valid", 32'(kif.key_valid), 32'd1);
    cycles(11);
    check("k1_pulses", 32'(pulses - base), 32'd1);

    // Direct changes without release: 0, *, #, 5, 8
    base = pulses;
    for (int i = 0; i < 5; i++) begin
      pressed = 12'd1 << seq_idx[i];
      cycles(25);
      check($sformatf("chg_key_%0d", seq_key[i]), 32'(kif.key), 32'(seq_key[i]));
      check($sformatf("chg_valid_%0d", seq_key[i]), 32'(kif.key_valid), 32'd1);
      cycles(11);
    end
    check("chg_pulses", 32'(pulses - base), 32'd5);

    // Reset mid-hold of 8
    base = pulses;
    cycles(5);
    reset = 1'b1;
    pressed = '0;
    cycles(2);
    check("mid_rst_key", 32'(kif.key), 32'd10);
    check("mid_rst_held", 32'(kif.key_held), 32'd0);
    check("mid_rst_col_n", 32'(col_n), 32'(3'b110));
    reset = 1'b0;
    cycles(36);
    check("post_rst_key", 32'(kif.key), 32'd10);
    check("post_rst_pulses", 32'(pulses - base), 32'd0);

    // Hold 7 for 70 scans
    base = pulses;
    pressed = 12'd1 << 6;
    cycles(25);
    check("k7_key", 32'(kif.key), 32'd7);
    check("k7_valid", 32'(kif.key_valid), 32'd1);
    cycles(12 * 70 - 25);
`ifdef KEYPAD_REPEAT_EN
    check("k7_pulses", 32'(pulses - base), 32'd3);
`else
    check("k7_pulses", 32'(pulses - base), 32'd1);
`endif
    pressed = '0;
    cycles(36);
    check("k7_release", 32'(kif.key), 32'd10);
    check("no_double_pulse", 32'(double_seen), 32'd0);
    check("no_nokey_pulse", 32'(nokey_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
